// File: rtl/pipe_pkg.sv
// Shared types and defaults for the ID/EX pipeline slice: the decoder control
// bundle, the bubble constant and the default operand/specifier widths.
package pipe_pkg;

    typedef struct packed {
        logic regwrite;
        logic regdst;
        logic aluop;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    localparam ctrl_t       CTRL_BUBBLE = '0;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_AW_DEF  = 5;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a valid load in EX whose destination
// (rt, non-zero) is a source of the valid instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic              i_id_uses_rt,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    output logic              o_haz
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_ex_load;

    always_comb begin
        w_ex_load  = i_ex_valid & i_ex_memread & (i_ex_rt != '0);
        w_rs_match = (i_ex_rt == i_id_rs);
        w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);
        o_haz      = w_ex_load & i_id_valid & (w_rs_match | w_rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush-to-bubble.
// Optional saturating stall counter on port stall_count when STALL_CNT_EN is defined.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_regwrite,
    input  logic              id_regdst,
    input  logic              id_aluop,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_branch,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_regdst,
    output logic              ex_aluop,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;

    ctrl_t             w_id_ctrl;
    logic              w_haz;
    logic              w_bubble;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_ex_valid   (r_valid),
        .i_ex_memread (r_ctrl.memread),
        .i_ex_rt      (r_rt),
        .i_id_valid   (id_valid),
        .i_id_uses_rt (id_uses_rt),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .o_haz        (w_haz)
    );

    // Controls of an invalid decode slot are squashed so garbage never reaches EX.
    always_comb begin
        w_id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            w_id_ctrl = '{regwrite: id_regwrite, regdst: id_regdst, aluop: id_aluop,
                          memread: id_memread, memwrite: id_memwrite,
                          memtoreg: id_memtoreg, branch: id_branch};
        end
        w_bubble = flush | w_haz;
        stall    = w_haz & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_ctrl   <= CTRL_BUBBLE;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
            r_pc4    <= '0;
        end else begin
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_rdata1 <= id_rdata1;
            r_rdata2 <= id_rdata2;
            r_imm    <= id_imm;
            r_pc4    <= id_pc4;
            if (w_bubble) begin
                r_valid <= 1'b0;
                r_ctrl  <= CTRL_BUBBLE;
            end else begin
                r_valid <= id_valid;
                r_ctrl  <= w_id_ctrl;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;
`else
    logic [STALL_CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

    always_comb begin
        ex_valid    = r_valid;
        ex_regwrite = r_ctrl.regwrite;
        ex_regdst   = r_ctrl.regdst;
        ex_aluop    = r_ctrl.aluop;
        ex_memread  = r_ctrl.memread;
        ex_memwrite = r_ctrl.memwrite;
        ex_memtoreg = r_ctrl.memtoreg;
        ex_branch   = r_ctrl.branch;
        ex_rs       = r_rs;
        ex_rt       = r_rt;
        ex_rd       = r_rd;
        ex_rdata1   = r_rdata1;
        ex_rdata2   = r_rdata2;
        ex_imm      = r_imm;
        ex_pc4      = r_pc4;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register. Sits directly downstream of the opcode decoder: it captures the decoder's seven control bits plus the decode-stage operands, and presents them to EX one cycle later.
- Owns load-use hazard detection. It raises `stall` to freeze PC and IF/ID, and inserts a bubble into EX.
- Honours a branch/jump `flush` from the later stage that resolves control flow.

Parameters:
- DATA_W, 32, width of register operands, immediate and pc_plus4.
- REG_AW, 5, register-specifier width.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_regwrite, id_regdst, id_aluop, id_memread, id_memwrite, id_memtoreg, id_branch  in  1 each  control bits from the opcode decoder
- id_uses_rt  in  1  instruction reads rt as a source (sub, sw)
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers
- id_rdata1, id_rdata2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the decode instruction
- flush  in  1  kill the decode-stage instruction (branch/jump taken)
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  EX stage holds a real instruction
- ex_regwrite, ex_regdst, ex_aluop, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1 each  registered control bits
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered specifiers
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
- stall_count  out  STALL_CNT_W  only present with STALL_CNT_EN

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge.
- Reset: every registered output is 0, including ex_valid and all control bits; stall_count is 0.
- Hazard: haz = ex_valid & ex_memread & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall = haz & ~flush. It is purely combinational, with no registered delay.
- Per-edge priority: rst > flush > haz > normal load.
- flush = 1: load a bubble. ex_valid = 0 and all seven control bits = 0. Data/specifier fields still capture their inputs (don't-care, deterministic).
- haz = 1, no flush: load a bubble as above. IF/ID holds via stall, so the same instruction is re-presented next cycle; the hazard then clears because EX holds the bubble.
- Normal: all fields capture their id_* inputs; ex_valid = id_valid.
- When id_valid = 0, the control bits are forced to 0 on capture, so decoder X/garbage never reaches EX.
- Latency: exactly 1 cycle from ID to EX. A load-use pair costs exactly 1 bubble.
- Back-to-back loads feeding each other stall once per dependent pair; there is never a 2-cycle stall.
- A reset asserted mid-stall clears EX and drops stall the next cycle, because ex_valid = 0.
- rt == 0 never stalls, since register 0 is hard-wired.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: the stall_count port exists. The counter increments by 1 on every edge where stall = 1, saturates at all-ones with no wrap, and is cleared by rst.
- Undefined: there is no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - a packed ctrl_t struct carrying regwrite, regdst, aluop, memread, memwrite, memtoreg, branch;
  - constant CTRL_BUBBLE = all zero;
  - the REG_AW and DATA_W defaults.
- One sub-module, load_use_detect, is natural. It is purely combinational and computes haz from the EX and ID fields. The register bank stays in id_ex_stage.

Test Plan:
1. Reset: hold rst for 2 cycles with non-zero inputs -> all ex_* = 0, stall = 0, stall_count = 0.
2. Pass-through: lw with id_rt = 8, id_imm = 0x0000_0004, id_valid = 1 -> next cycle ex_memread = 1, ex_regwrite = 1, ex_memtoreg = 1, ex_rt = 8, ex_imm = 4, ex_valid = 1.
3. Load-use: lw rt = 8, then sub with rs = 8 -> stall = 1 for exactly 1 cycle, EX sees a bubble (ex_valid = 0, controls 0), then sub enters EX with ex_rs = 8; stall_count = 1.
4. No false stall:
   - lw rt = 8, then xori with rt = 8 and rs = 3 (id_uses_rt = 0) -> stall = 0.
   - lw rt = 0, then sub rs = 0 -> stall = 0.
5. Flush vs hazard: a load-use condition with flush = 1 in the same cycle -> stall = 0, EX gets a bubble, stall_count unchanged.
6. Saturation (STALL_CNT_EN, STALL_CNT_W = 4): force 20 consecutive hazard cycles -> stall_count stops at 15.
